uart_tx_fifo_drain: RTL and testbench

- UART transmitter that drains `uart_fifo` from its read side. It pops one word at a time and serialises it as a start bit, data LSB-first, an optional parity bit and one or two stop bits.
- It sits between the TX-path `uart_fifo` instance, whose write side is fed by the bridge command logic, and the external TX pin.
- Data and status flow opposite to the RX path, which writes `uart_fifo`.

---
 rtl/uart_tx_fifo_drain.sv | 124 ++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a show-ahead FIFO: start, LSB-first data, optional parity, 1-2 stops.
// Start bit appears 1 clk after the pop; pops only when idle, enabled and FIFO non-empty.
module uart_tx_fifo_drain #(
  parameter int    DATA_WIDTH   = 8,
  parameter int    CLKS_PER_BIT = 868,
  parameter string PARITY       = "NONE",
  parameter int    STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W     = $clog2(CLKS_PER_BIT);
  localparam int BIT_W      = $clog2(DATA_WIDTH);
  localparam bit HAS_PARITY = (PARITY != "NONE");
  localparam bit ODD_PARITY = (PARITY == "ODD");

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    bit_end;

  assign fifo_rd_en = !rst && (state_q == S_IDLE) && en && !fifo_empty;
  assign bit_end    = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;

  always_comb begin
    state_d    = state_q;
    baud_d     = bit_end ? '0 : baud_q + BAUD_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (fifo_rd_en) begin
          state_d = S_START;
          shift_d = fifo_dout;
          // Parity is taken from the whole word at capture time, before any shifting.
          par_d   = (^fifo_dout) ^ ODD_PARITY;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = HAS_PARITY ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PAR: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        // bit_q is reused to count stop bits.
        if (bit_end) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
            bit_d      = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so it only moves on bit boundaries.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three configurations driven from per-lane FIFOs,
// compared each cycle against a frame-timeline reference model.
module tb_uart_tx_fifo_drain;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] f_empty;
  logic [2:0] rd_en;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] done;
  logic [8:0] dout [3];

  int n_vec;
  int n_err;
  int cyc;

  int fmem [3][256];
  int wp [3];
  int rp [3];
  bit inf [3];
  int fs [3];
  int flen [3];
  bit fbits [3][16];
  bit rd_seen [3];

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY("NONE"), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(f_empty[0]), .fifo_dout(dout[0][7:0]),
    .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(done[0]));

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY("EVEN"), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(f_empty[1]), .fifo_dout(dout[1][7:0]),
    .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(done[1]));

  uart_tx_fifo_drain #(.DATA_WIDTH(7), .CLKS_PER_BIT(3), .PARITY("ODD"), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(f_empty[2]), .fifo_dout(dout[2][6:0]),
    .fifo_rd_en(rd_en[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane configuration: parity 0=none, 1=even, 2=odd.
  function automatic int cfg_cpb(int l);  return (l == 2) ? 3 : 4; endfunction
  function automatic int cfg_dw(int l);   return (l == 2) ? 7 : 8; endfunction
  function automatic int cfg_par(int l);  return l;                endfunction
  function automatic int cfg_stop(int l); return (l == 1) ? 2 : 1; endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input int l, input int w);
    fmem[l][wp[l] % 256] = w & ((1 << cfg_dw(l)) - 1);
    wp[l]++;
  endtask

  task automatic update_ports();
    for (int l = 0; l < 3; l++) begin
      f_empty[l] = (wp[l] == rp[l]);
      dout[l]    = 9'(fmem[l][rp[l] % 256]);
    end
  endtask

  task automatic apply_stimulus(input int c);
    rst = (c < 3) || (c == 714) || (c >= 800 && $urandom_range(799, 0) == 0);
    if (c < 360)       en = 1'b1;
    else if (c < 460)  en = 1'b0;
    else if (c < 800)  en = 1'b1;
    else if ($urandom_range(49, 0) == 0) en = ~en;
    for (int l = 0; l < 3; l++) begin
      if (c == 100) push(l, 'hA5);
      if (c == 200) begin push(l, 'h00); push(l, 'hFF); push(l, 'h3C); end
      if (c == 340) for (int k = 0; k < 3; k++) push(l, int'($urandom));
      if (c == 700) for (int k = 0; k < 2; k++) push(l, int'($urandom));
      if (c >= 800 && (wp[l] - rp[l]) < 8 && $urandom_range(29, 0) == 0) push(l, int'($urandom));
    end
  endtask

  // Model: a frame is a list of bit levels, each CPB clocks long, starting the cycle after its pop.
  task automatic model_and_check(input int c);
    int  cpb, w, nb, ones, p, L;
    bit  act, idle, e_tx, e_rd;
    for (int l = 0; l < 3; l++) begin
      cpb  = cfg_cpb(l);
      L    = flen[l];
      act  = inf[l] && (c > fs[l]) && (c <= fs[l] + L);
      idle = !(inf[l] && (c <= fs[l] + L));
      e_tx = act ? fbits[l][(c - fs[l] - 1) / cpb] : 1'b1;
      e_rd = !rst && en && (wp[l] != rp[l]) && idle;
      check_eq($sformatf("tx%0d@%0d", l, c), int'(tx[l]), int'(e_tx));
      check_eq($sformatf("busy%0d@%0d", l, c), int'(busy[l]), int'(act));
      check_eq($sformatf("done%0d@%0d", l, c), int'(done[l]), int'(act && (c == fs[l] + L)));
      check_eq($sformatf("rd_en%0d@%0d", l, c), int'(rd_en[l]), int'(e_rd));
      rd_seen[l] = rd_en[l];
      if (e_rd) begin
        w  = fmem[l][rp[l] % 256];
        nb = 0;
        ones = 0;
        fbits[l][nb] = 1'b0; nb++;
        for (int i = 0; i < cfg_dw(l); i++) begin
          fbits[l][nb] = ((w >> i) & 1) != 0;
          ones += (w >> i) & 1;
          nb++;
        end
        if (cfg_par(l) != 0) begin
          p = ones % 2;
          if (cfg_par(l) == 2) p = 1 - p;
          fbits[l][nb] = (p != 0); nb++;
        end
        for (int s = 0; s < cfg_stop(l); s++) begin
          fbits[l][nb] = 1'b1; nb++;
        end
        flen[l] = nb * cpb;
        fs[l]   = c;
        inf[l]  = 1'b1;
      end
      if (rst) inf[l] = 1'b0;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    en    = 1'b1;
    for (int l = 0; l < 3; l++) begin
      wp[l] = 0; rp[l] = 0; inf[l] = 1'b0; fs[l] = 0; flen[l] = 0; rd_seen[l] = 1'b0;
      for (int k = 0; k < 256; k++) fmem[l][k] = 0;
    end
    update_ports();
    for (cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      #1;
      for (int l = 0; l < 3; l++)
        if (rd_seen[l] && rp[l] != wp[l]) rp[l]++;
      apply_stimulus(cyc);
      update_ports();
      @(negedge clk);
      model_and_check(cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
